// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter that holds each grant until release,
// with an optional grant-hold timeout enabled by defining GRANT_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_id_o,
    output logic       busy_o,
    output logic       expired_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;
    logic [1:0] win_id_d;
    logic [1:0] scan_idx;
    logic       win_vld_d;
    logic       timeout_hit;

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_cnt_q;
    logic       expired_q;

    // The count before the edge is one less than the cycles gnt has been high.
    assign timeout_hit = (hold_cnt_q == 8'(TIMEOUT - 1));
    assign expired_o   = expired_q;
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign expired_o      = 1'b0;
`endif

    // Scan from farthest to nearest so the first requester after ptr wins.
    always_comb begin
        win_id_d  = ptr_q;
        scan_idx  = ptr_q;
        win_vld_d = |req_i;
        for (int i = 4; i >= 1; i--) begin
            scan_idx = ptr_q + 2'(i);
            if (req_i[scan_idx]) win_id_d = scan_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= 2'b11;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'b00;
            busy_q     <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt_q <= 8'd0;
            expired_q  <= 1'b0;
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
            expired_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (enable_i && win_vld_d) begin
                        state_q    <= GRANT;
                        gnt_q      <= 4'b0001 << win_id_d;
                        gnt_id_q   <= win_id_d;
                        busy_q     <= 1'b1;
                        ptr_q      <= win_id_d;
`ifdef GRANT_TIMEOUT_EN
                        hold_cnt_q <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    // Release wins over a coincident timeout.
                    if (!enable_i || !req_i[gnt_id_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
                        expired_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; expectations follow the GRANT_TIMEOUT_EN build setting.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expired;

    int checks = 0;
    int errors = 0;

    rr_arbiter_4 #(.TIMEOUT(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .req_i    (req),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .busy_o   (busy),
        .expired_o(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks gnt/busy/expired together, and gnt_id whenever a grant is expected.
    task automatic expect_out(input string tag, input logic [3:0] e_gnt,
                              input logic [1:0] e_id, input logic e_exp);
        logic [5:0] obs;
        logic [5:0] exp_v;
        obs   = {gnt, busy, expired};
        exp_v = {e_gnt, |e_gnt, e_exp};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: {gnt,busy,expired} got %b expected %b", tag, obs, exp_v);
        end
        if (|e_gnt) begin
            checks++;
            assert (gnt_id === e_id) else begin
                errors++;
                $error("FAIL %s_id: gnt_id got %0d expected %0d", tag, gnt_id, e_id);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req = 4'b0000;
        step(); step();
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        checks++;
        assert (gnt_id === 2'd0) else begin
            errors++;
            $error("FAIL reset_id: gnt_id got %0d expected 0", gnt_id);
        end

        // Reset priority starts at requester 0; no combinational path to gnt.
        rst = 1'b0; enable = 1'b1; req = 4'b1111;
        #1;
        expect_out("no_comb_path", 4'b0000, 2'd0, 1'b0);
        step();
        expect_out("first_grant", 4'b0001, 2'd0, 1'b0);
        step();
        expect_out("hold_ignore_others", 4'b0001, 2'd0, 1'b0);
        req = 4'b1110;
        step();
        expect_out("release_idle", 4'b0000, 2'd0, 1'b0);
        step();
        expect_out("next_grant_1", 4'b0010, 2'd1, 1'b0);

        // Alternating requesters 1 and 3.
        req = 4'b1010;
        step(); step();
        expect_out("alt_hold_1", 4'b0010, 2'd1, 1'b0);
        req = 4'b1000;
        step();
        expect_out("alt_idle_a", 4'b0000, 2'd0, 1'b0);
        req = 4'b1010;
        step();
        expect_out("alt_grant_3", 4'b1000, 2'd3, 1'b0);
        step(); step();
        expect_out("alt_hold_3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0010;
        step();
        expect_out("alt_idle_b", 4'b0000, 2'd0, 1'b0);
        req = 4'b1010;
        step();
        expect_out("alt_grant_1", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        step();

        // A request from 0 during a grant to 2 waits for the release.
        req = 4'b0100;
        step();
        expect_out("grant_2", 4'b0100, 2'd2, 1'b0);
        req = 4'b0101;
        step();
        expect_out("nonholder_ignored", 4'b0100, 2'd2, 1'b0);
        req = 4'b0001;
        step();
        expect_out("release_2", 4'b0000, 2'd0, 1'b0);
        step();
        expect_out("grant_0_after_gap", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();

        // enable low revokes but keeps ptr.
        req = 4'b1000;
        step();
        expect_out("grant_3", 4'b1000, 2'd3, 1'b0);
        enable = 1'b0;
        step();
        expect_out("disable_revoke", 4'b0000, 2'd0, 1'b0);
        enable = 1'b1;
        step();
        expect_out("reenable_grant_3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0000;
        step();
        req = 4'b1111;
        step();
        expect_out("ptr_kept_3", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();

        // Reset mid-grant overrides enable and req.
        req = 4'b0100;
        step();
        expect_out("grant_2_prerst", 4'b0100, 2'd2, 1'b0);
        rst = 1'b1;
        step();
        expect_out("rst_revoke", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; req = 4'b1111;
        step();
        expect_out("post_rst_grant_0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();

        // A lone requester is re-granted after one idle cycle.
        req = 4'b0100;
        step();
        expect_out("single_grant_a", 4'b0100, 2'd2, 1'b0);
        req = 4'b0000;
        step();
        expect_out("single_idle", 4'b0000, 2'd0, 1'b0);
        req = 4'b0100;
        step();
        expect_out("single_grant_b", 4'b0100, 2'd2, 1'b0);
        req = 4'b0000;
        step();

        // ptr=2 here, so requester 0 wins over 1.
        req = 4'b0011;
        step();
        expect_out("tmo_grant_0", 4'b0001, 2'd0, 1'b0);
`ifdef GRANT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step();
            expect_out("tmo_hold", 4'b0001, 2'd0, 1'b0);
        end
        step();
        expect_out("tmo_expire", 4'b0000, 2'd0, 1'b1);
        step();
        expect_out("tmo_next_grant_1", 4'b0010, 2'd1, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out("no_tmo_hold", 4'b0001, 2'd0, 1'b0);
        end
`endif
        req = 4'b0000;
        step();
        expect_out("final_idle", 4'b0000, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: TIMEOUT, 8, grant-hold limit in cycles (range 2..255); used only when GRANT_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 enable  input  1  arbiter enable; low forces the block idle with no grant.
REQ-005 req  input  4  per-requester request; held high for as long as the resource is wanted.
REQ-006 gnt  output  4  registered one-hot grant; 4'b0000 when no grant.
REQ-007 gnt_id  output  2  registered binary index of the granted requester; valid only while busy=1.
REQ-008 busy  output  1  registered; high while any grant is held.
REQ-009 expired  output  1  registered one-cycle pulse on a timeout revoke; constant 0 without GRANT_TIMEOUT_EN.

Function
REQ-010 FSM shall have two states: IDLE (gnt=0, busy=0) and GRANT (gnt one-hot, busy=1).
REQ-011 gnt shall always equal the 2-to-4 one-hot decode of gnt_id when busy=1, and 4'b0000 otherwise.
REQ-012 Pointer ptr[1:0] shall hold the index of the most recently granted requester.
REQ-013 Search order from IDLE shall be ptr+1, ptr+2, ptr+3, ptr (mod 4); the first index with req high wins.
REQ-014 IDLE->GRANT: at an edge where enable=1 and req!=0; gnt, gnt_id and busy update at that edge, and ptr is set to the winner.
REQ-015 Grant latency shall be exactly 1 cycle from req sampled high in IDLE to gnt visible.
REQ-016 GRANT->IDLE: at the first edge where req[gnt_id]=0; gnt clears at that edge.
REQ-017 There shall be at least one IDLE cycle between consecutive grants; no back-to-back handover.
REQ-018 Requests from non-holders during GRANT shall be ignored; they are arbitrated at the next IDLE edge.
REQ-019 enable=0 at an edge shall force IDLE, gnt=0 and busy=0; ptr shall be preserved.
REQ-020 A holder that drops and re-raises req shall lose priority to any other pending requester (pointer rotation).
REQ-021 A single active requester shall be re-granted after each one-cycle IDLE gap.
REQ-022 Inputs shall be sampled only at clock edges; outputs shall have no combinational path from inputs.

Reset
REQ-023 rst=1 at an edge shall set state=IDLE, gnt=4'b0000, gnt_id=2'b00, busy=0, expired=0, ptr=2'b11 (req[0] highest priority after reset), and the hold counter to 0.
REQ-024 rst shall take precedence over enable and req; rst asserted mid-grant shall revoke the grant at that edge.

Configuration
REQ-025 Macro GRANT_TIMEOUT_EN: when defined, an 8-bit hold counter shall clear on entry to GRANT and increment each GRANT cycle.
REQ-026 When defined, once gnt has been high for TIMEOUT cycles and req[gnt_id] is still 1, the block shall go to IDLE at that edge, clear gnt, and pulse expired=1 for exactly 1 cycle; ptr is unchanged, so the holder ranks last at the next arbitration.
REQ-027 When defined, a release and a timeout at the same edge shall be treated as a release (expired=0).
REQ-028 When not defined, no counter shall be built, the grant shall be held until release, and expired shall be tied to 0.

Verification
REQ-029 Reset then req=4'b1111, enable=1 -> one cycle later gnt=0001, gnt_id=0; after req[0] drops, one IDLE cycle, then gnt=0010.
REQ-030 req=4'b1010 held constant, each holder releasing after 3 cycles -> grant sequence 0010, 1000, 0010, with one idle cycle between grants.
REQ-031 Holding gnt=0100, assert req[0] -> gnt stays 0100 until req[2] drops; gnt=0001 two edges later.
REQ-032 Holding gnt=1000, drive enable=0 for 1 cycle -> gnt=0000 and busy=0 at the next edge; after enable returns with req=1000, gnt=1000 again (ptr=3 preserved).
REQ-033 rst=1 while gnt=0100 -> gnt=0000, ptr=3 at that edge; next grant with req=1111 is 0001.
REQ-034 GRANT_TIMEOUT_EN defined, TIMEOUT=8, req=0011 held -> gnt=0001 for 8 cycles, expired pulse, one IDLE cycle, then gnt=0010; without the macro, gnt=0001 is held indefinitely and expired stays 0.
